// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                  W_INC;
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic                  R_INC;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  RD_VALID;
   logic                  FULL;
   logic                  EMPTY;
   logic                  ALMOST_FULL;
   logic                  ALMOST_EMPTY;
   logic [CW-1:0]         COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_INC, WR_DATA, R_INC,
      input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_INC, WR_DATA, R_INC,
      output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and optional FWFT.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter bit FWFT       = 1'b0
) (
   input logic        CLK,
   input logic        RST,
   sync_fifo_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
   localparam logic [AW-1:0] C_LAST  = AW'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic [AW-1:0]         w_wptr_nxt;
   logic [AW-1:0]         w_rptr_nxt;

   // All status flags derive from the occupancy register alone.
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_wr_en = bus.W_INC && !w_full;
   assign w_rd_en = bus.R_INC && !w_empty;

   // Depth need not be a power of two, so wrap explicitly.
   assign w_wptr_nxt = (r_wptr == C_LAST) ? '0 : r_wptr + AW'(1);
   assign w_rptr_nxt = (r_rptr == C_LAST) ? '0 : r_rptr + AW'(1);

   always_ff @(posedge CLK) begin
      if (!RST && w_wr_en) begin
         r_mem[r_wptr] <= bus.WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wr_en) r_wptr <= w_wptr_nxt;
         if (w_rd_en) r_rptr <= w_rptr_nxt;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_ovf <= bus.W_INC && w_full;
         r_udf <= bus.R_INC && w_empty;
      end
   end

   assign bus.FULL         = w_full;
   assign bus.EMPTY        = w_empty;
   assign bus.ALMOST_FULL  = (r_count >= C_AF);
   assign bus.ALMOST_EMPTY = (r_count <= C_AE);
   assign bus.COUNT        = r_count;
   assign bus.OVERFLOW     = r_ovf;
   assign bus.UNDERFLOW    = r_udf;

   generate
      if (FWFT) begin : g_fwft
         assign bus.RD_DATA  = r_mem[r_rptr];
         assign bus.RD_VALID = !w_empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         always_ff @(posedge CLK) begin
            if (RST) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_en;
               if (w_rd_en) r_rd_data <= r_mem[r_rptr];
            end
         end

         assign bus.RD_DATA  = r_rd_data;
         assign bus.RD_VALID = r_rd_valid;
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: depth-5 registered-read instance (u_dut0)
// and depth-5 first-word-fall-through instance (u_dut1).
module tb_sync_fifo;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) b0 ();
   sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) b1 ();

   sync_fifo #(
      .DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b0)
   ) u_dut0 (.CLK(clk), .RST(rst), .bus(b0));

   sync_fifo #(
      .DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b1)
   ) u_dut1 (.CLK(clk), .RST(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic w, input logic [7:0] d, input logic r);
      b0.W_INC = w; b0.WR_DATA = d; b0.R_INC = r;
   endtask

   task automatic set1(input logic w, input logic [7:0] d, input logic r);
      b1.W_INC = w; b1.WR_DATA = d; b1.R_INC = r;
   endtask

   task automatic wr0(input logic [7:0] d, input logic [31:0] exp_cnt);
      set0(1'b1, d, 1'b0);
      tick();
      set0(1'b0, 8'h00, 1'b0);
      chk("wr_count", b0.COUNT, exp_cnt);
   endtask

   task automatic rd0(input logic [7:0] exp_d, input logic [31:0] exp_cnt);
      set0(1'b0, 8'h00, 1'b1);
      tick();
      set0(1'b0, 8'h00, 1'b0);
      chk("rd_valid", b0.RD_VALID, 1);
      chk("rd_data", b0.RD_DATA, exp_d);
      chk("rd_count", b0.COUNT, exp_cnt);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      set0(1'b0, 8'h00, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      tick();
      tick();
      chk("rst_count", b0.COUNT, 0);
      chk("rst_empty", b0.EMPTY, 1);
      chk("rst_full", b0.FULL, 0);
      chk("rst_ae", b0.ALMOST_EMPTY, 1);
      chk("rst_af", b0.ALMOST_FULL, 0);
      chk("rst_valid", b0.RD_VALID, 0);
      chk("rst_data", b0.RD_DATA, 0);
      chk("rst_ovf", b0.OVERFLOW, 0);
      chk("rst_udf", b0.UNDERFLOW, 0);
      rst = 1'b0;

      // Fill: thresholds AF at >=4, AE at <=1
      wr0(8'h11, 1); chk("af_c1", b0.ALMOST_FULL, 0); chk("ae_c1", b0.ALMOST_EMPTY, 1);
      wr0(8'h12, 2); chk("af_c2", b0.ALMOST_FULL, 0); chk("ae_c2", b0.ALMOST_EMPTY, 0);
      wr0(8'h13, 3); chk("af_c3", b0.ALMOST_FULL, 0);
      wr0(8'h14, 4); chk("af_c4", b0.ALMOST_FULL, 1); chk("full_c4", b0.FULL, 0);
      wr0(8'h15, 5); chk("full_c5", b0.FULL, 1);

      set0(1'b1, 8'h16, 1'b0);
      tick();
      set0(1'b0, 8'h00, 1'b0);
      chk("ovf_pulse", b0.OVERFLOW, 1);
      chk("ovf_count", b0.COUNT, 5);
      tick();
      chk("ovf_clear", b0.OVERFLOW, 0);

      rd0(8'h11, 4); chk("af_r4", b0.ALMOST_FULL, 1);
      rd0(8'h12, 3); chk("af_r3", b0.ALMOST_FULL, 0);
      rd0(8'h13, 2); chk("ae_r2", b0.ALMOST_EMPTY, 0);
      rd0(8'h14, 1); chk("ae_r1", b0.ALMOST_EMPTY, 1);
      rd0(8'h15, 0); chk("empty_r0", b0.EMPTY, 1);
      tick();
      chk("valid_drop", b0.RD_VALID, 0);
      chk("data_hold", b0.RD_DATA, 8'h15);

      // Pointer wrap across 4 -> 0
      wr0(8'h21, 1); wr0(8'h22, 2); wr0(8'h23, 3);
      rd0(8'h21, 2); rd0(8'h22, 1); rd0(8'h23, 0);
      wr0(8'h31, 1); wr0(8'h32, 2); wr0(8'h33, 3); wr0(8'h34, 4); wr0(8'h35, 5);
      rd0(8'h31, 4); rd0(8'h32, 3); rd0(8'h33, 2); rd0(8'h34, 1); rd0(8'h35, 0);

      // Sustained simultaneous read/write at COUNT=2
      wr0(8'h41, 1); wr0(8'h42, 2);
      for (int i = 0; i < 10; i++) begin
         set0(1'b1, 8'(8'h43 + i), 1'b1);
         tick();
         chk("sim_data", b0.RD_DATA, 8'(8'h41 + i));
         chk("sim_valid", b0.RD_VALID, 1);
         chk("sim_count", b0.COUNT, 2);
      end
      set0(1'b0, 8'h00, 1'b0);
      rd0(8'h4B, 1); rd0(8'h4C, 0);

      // Simultaneous when full
      wr0(8'h51, 1); wr0(8'h52, 2); wr0(8'h53, 3); wr0(8'h54, 4); wr0(8'h55, 5);
      set0(1'b1, 8'h56, 1'b1);
      tick();
      set0(1'b0, 8'h00, 1'b0);
      chk("full_sim_data", b0.RD_DATA, 8'h51);
      chk("full_sim_ovf", b0.OVERFLOW, 1);
      chk("full_sim_count", b0.COUNT, 4);
      chk("full_sim_full", b0.FULL, 0);
      rd0(8'h52, 3); chk("ovf_one_cycle", b0.OVERFLOW, 0);
      rd0(8'h53, 2); rd0(8'h54, 1); rd0(8'h55, 0);

      // Simultaneous when empty
      set0(1'b1, 8'h61, 1'b1);
      tick();
      set0(1'b0, 8'h00, 1'b0);
      chk("empty_sim_udf", b0.UNDERFLOW, 1);
      chk("empty_sim_count", b0.COUNT, 1);
      chk("empty_sim_valid", b0.RD_VALID, 0);
      chk("empty_sim_empty", b0.EMPTY, 0);
      rd0(8'h61, 0); chk("udf_one_cycle", b0.UNDERFLOW, 0);

      // Reset wins over simultaneous requests
      wr0(8'h71, 1); wr0(8'h72, 2); wr0(8'h73, 3);
      rst = 1'b1;
      set0(1'b1, 8'h74, 1'b1);
      tick();
      rst = 1'b0;
      set0(1'b0, 8'h00, 1'b0);
      chk("mrst_count", b0.COUNT, 0);
      chk("mrst_empty", b0.EMPTY, 1);
      chk("mrst_valid", b0.RD_VALID, 0);
      chk("mrst_ovf", b0.OVERFLOW, 0);
      chk("mrst_udf", b0.UNDERFLOW, 0);
      chk("mrst_data", b0.RD_DATA, 0);
      wr0(8'h81, 1);
      rd0(8'h81, 0);
      chk("mrst_final_empty", b0.EMPTY, 1);

      // First-word-fall-through instance
      chk("fw_rst_valid", b1.RD_VALID, 0);
      chk("fw_rst_empty", b1.EMPTY, 1);
      set1(1'b1, 8'hA5, 1'b0);
      tick();
      set1(1'b0, 8'h00, 1'b0);
      chk("fw_valid", b1.RD_VALID, 1);
      chk("fw_data", b1.RD_DATA, 8'hA5);
      chk("fw_count", b1.COUNT, 1);
      tick();
      chk("fw_hold_valid", b1.RD_VALID, 1);
      chk("fw_hold_data", b1.RD_DATA, 8'hA5);
      set1(1'b0, 8'h00, 1'b1);
      tick();
      chk("fw_pop_empty", b1.EMPTY, 1);
      chk("fw_pop_valid", b1.RD_VALID, 0);
      chk("fw_pop_udf", b1.UNDERFLOW, 0);
      tick();
      set1(1'b0, 8'h00, 1'b0);
      chk("fw_udf", b1.UNDERFLOW, 1);
      tick();
      chk("fw_udf_clear", b1.UNDERFLOW, 0);
      set1(1'b1, 8'hB1, 1'b0);
      tick();
      set1(1'b1, 8'hB2, 1'b0);
      tick();
      set1(1'b0, 8'h00, 1'b0);
      chk("fw_head", b1.RD_DATA, 8'hB1);
      chk("fw_count2", b1.COUNT, 2);
      set1(1'b0, 8'h00, 1'b1);
      tick();
      set1(1'b0, 8'h00, 1'b0);
      chk("fw_next", b1.RD_DATA, 8'hB2);
      chk("fw_next_valid", b1.RD_VALID, 1);
      chk("fw_count1", b1.COUNT, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised synchronous FIFO: the same-domain successor to the team's dual-clock FIFO, for buffering inside one clock domain (e.g. the UART TX queue or register-file command queue). It adds non-power-of-two depth, programmable almost-full/almost-empty thresholds, a live occupancy count, overflow/underflow pulses and a selectable first-word-fall-through (FWFT) read mode. No synchronisers; pointers are binary.

## Interface
- DATA_WIDTH, 8, width of each stored word
- FIFO_DEPTH, 8, number of entries; any integer ≥ 2, power of two not required
- AF_THRESH, FIFO_DEPTH-1, ALMOST_FULL asserted when COUNT ≥ AF_THRESH; legal range 1..FIFO_DEPTH
- AE_THRESH, 1, ALMOST_EMPTY asserted when COUNT ≤ AE_THRESH; legal range 0..FIFO_DEPTH-1
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode
- Localparam CW = $clog2(FIFO_DEPTH+1); AW = $clog2(FIFO_DEPTH)

- CLK  in  1  single clock; all state on rising edge
- RST  in  1  synchronous reset, active-high
- W_INC  in  1  write request
- WR_DATA  in  DATA_WIDTH  write data, sampled with W_INC
- R_INC  in  1  read request
- RD_DATA  out  DATA_WIDTH  read data
- RD_VALID  out  1  RD_DATA qualifier (meaning depends on FWFT)
- FULL  out  1  COUNT == FIFO_DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT ≥ AF_THRESH
- ALMOST_EMPTY  out  1  COUNT ≤ AE_THRESH
- COUNT  out  CW  current occupancy
- OVERFLOW  out  1  one-cycle pulse: write rejected
- UNDERFLOW  out  1  one-cycle pulse: read rejected

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array, not reset. Write pointer and read pointer are AW-bit binary, wrap FIFO_DEPTH-1 → 0 (explicit compare, not natural rollover).
- Occupancy register COUNT (CW bits) is the single source of truth; FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY decode combinationally from COUNT only.
- Write accepted (wr_en) iff W_INC && !FULL: mem[wptr] ← WR_DATA, wptr advances.
- Read accepted (rd_en) iff R_INC && !EMPTY: rptr advances.
- COUNT update: +1 on wr_en only, −1 on rd_en only, unchanged on both or neither.
- Simultaneous W_INC and R_INC:
  - Mid-range: both accepted, COUNT unchanged.
  - When FULL: read accepted, write rejected, OVERFLOW pulses.
  - When EMPTY: write accepted, read rejected, UNDERFLOW pulses. No write-through bypass.
- OVERFLOW = registered (W_INC && FULL); UNDERFLOW = registered (R_INC && EMPTY).
- FWFT=0:
  - RD_DATA register ← mem[rptr] on rd_en; it holds otherwise.
  - RD_VALID register = rd_en of the previous cycle.
- FWFT=1:
  - RD_DATA = mem[rptr] combinationally.
  - RD_VALID = !EMPTY.
  - R_INC acts as acknowledge/pop of the displayed word.
- RST (synchronous) has priority over W_INC/R_INC in the same cycle. It clears wptr, rptr, COUNT, the RD_DATA register, RD_VALID, OVERFLOW and UNDERFLOW. Memory contents are left as is, and nothing stored is readable after reset.

## Timing
- Reset values: COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0. RD_DATA=0 when FWFT=0; when FWFT=1 it is don't-care while RD_VALID=0.
- Status flags and COUNT reflect all accepted operations one edge after the request edge.
- FWFT=0 read latency: R_INC sampled at edge N → RD_DATA/RD_VALID valid after edge N+1, for one cycle of RD_VALID.
- FWFT=1: a word written at edge N into an empty FIFO gives RD_VALID=1 and RD_DATA = that word after edge N (one-cycle write-to-visible latency).
- Full throughput: one write and one read per cycle, sustained, with no bubbles.
- OVERFLOW/UNDERFLOW assert for exactly the cycle after the rejected request edge.

## Test plan
- Reset, then FIFO_DEPTH=5, FWFT=0: write 0x11..0x15 on consecutive cycles → FULL=1, COUNT=5. A 6th write 0x16 → OVERFLOW pulse, COUNT stays 5. Five reads → RD_DATA 0x11..0x15, each with RD_VALID 1 cycle later; then EMPTY=1.
- Pointer wrap at depth 5: 3 writes, 3 reads, then 5 writes and 5 reads → data order preserved across the 4→0 wrap, COUNT returns to 0.
- Simultaneous traffic: at COUNT=2, W_INC+R_INC for 10 cycles → COUNT stays 2 and output order is intact. When FULL, W_INC+R_INC → read accepted, OVERFLOW=1, COUNT=DEPTH-1. When EMPTY, W_INC+R_INC → UNDERFLOW=1, COUNT=1.
- Thresholds with AF_THRESH=4, AE_THRESH=1, depth 5: ALMOST_FULL rises as COUNT goes 3→4 and falls as it goes 4→3. ALMOST_EMPTY is high at COUNT 0 and 1 and low at 2.
- FWFT=1: write 0xA5 into an empty FIFO → next cycle RD_VALID=1, RD_DATA=0xA5 with no R_INC. R_INC pops it → EMPTY=1, RD_VALID=0. R_INC while empty → UNDERFLOW pulse.
- Mid-operation reset: at COUNT=3, assert RST together with W_INC and R_INC → next cycle COUNT=0, EMPTY=1, RD_VALID=0, no OVERFLOW/UNDERFLOW. A subsequent write and read returns the new word only.
